bram_stream_ctrl: RTL

Sequencing master for the single-port BRAM_50K buffer (1600 × 32-bit, write on clock edge, asynchronous read). Accepts block commands and either fills a contiguous address range from an input valid/ready stream or dumps a range to an output valid/ready stream. It drives the memory's we/addr/din pins and consumes its dout. It sits between the compute datapath and the buffer so that no other block sequences addresses directly.

---
 rtl/bram_stream_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_ctrl.sv
// Block-command sequencer for the single-port BRAM_50K buffer.
// Fills an address range from s_* or dumps a range to m_*.
module bram_stream_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1600,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_last,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WIDTH-1:0]      bram_din,
    input  logic [WIDTH-1:0]      bram_dout,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   ZERO    = '0;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  cmd_fire;
    logic                  cmd_bad;
    logic                  cmd_go;
    logic                  s_fire;
    logic                  rd_load;
    logic                  last_word;
    logic                  err_q;

    assign cmd_fire  = (state == IDLE) && cmd_valid;
    assign cmd_bad   = ({1'b0, cmd_base} >= DEPTH_L) || (cmd_len > DEPTH_L);
    assign cmd_go    = cmd_fire && !cmd_bad;
    assign s_fire    = (state == WRITE) && s_valid;
    assign rd_load   = (state == READ) && (!m_valid || m_ready);
    assign last_word = (remaining == ONE);

    // DEPTH is not a power of two, so the wrap needs an explicit compare
    assign addr_inc  = (cur_addr == LAST_A) ? '0 : cur_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_go) begin
                    if (cmd_len == ZERO) begin
                        state_nxt = DONE;
                    end else if (cmd_write) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                if (s_fire && last_word) begin
                    state_nxt = DONE;
                end
            end
            READ: begin
                if (rd_load && last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = addr_q;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            WRITE: begin
                s_ready   = 1'b1;
                bram_we   = s_valid;
                bram_addr = cur_addr;
            end
            READ: begin
                bram_addr = cur_addr;
            end
            DRAIN: begin
                bram_addr = addr_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign bram_din = s_data;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= cmd_fire && cmd_bad;
            if (cmd_go) begin
                cur_addr  <= cmd_base;
                remaining <= cmd_len;
            end else if (s_fire || rd_load) begin
                cur_addr  <= addr_inc;
                remaining <= remaining - ONE;
            end
            if ((state == WRITE) || (state == READ)) begin
                addr_q <= cur_addr;
            end
        end
    end

    // A stalled word is never overwritten: loads only when empty or consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (rd_load) begin
            m_valid <= 1'b1;
            m_data  <= bram_dout;
            m_last  <= last_word;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule
